spi_s: RTL and testbench

// - SPI slave (mode 0, CPOL=0/CPHA=0, MSB first, cs active-low): far end of the spi_m master link.
// - Oversamples sclk/cs/mosi in the clk domain: deserialises mosi words to rx_data, serialises tx_data on miso.
// - Used as loopback/peer for spi_m bring-up and as the register-port front end of on-board peripherals.

---
 rtl/spi_s.sv | 159 +++++++++++++++
 tb/tb_spi_s.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_s.sv
// spi_s: SPI mode-0 slave (CPOL=0, CPHA=0, MSB first, active-low cs).
// The SPI pins are oversampled in the clk domain; every action is keyed off
// edges detected on the synchronised sclk/cs.
module spi_s #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_underrun,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int SET_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic [SET_W-1:0]       settle_cnt;
  logic                   settled;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic                   active, word_end, word_start, word_done;

  logic [DATA_W-1:0]      holding, tx_shift;
  logic                   tx_pend;
  logic [DATA_W-2:0]      rx_shift;
  logic [DATA_W-1:0]      rx_next;
  logic [CNT_W-1:0]       bit_cnt;

  // Synchronise the pins, keep one delayed copy for edge detection, and count
  // out the chain refill after reset so stale reset values are never trusted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync  <= '0;
      cs_sync    <= '1;
      mosi_sync  <= '0;
      sclk_d     <= 1'b0;
      cs_d       <= 1'b1;
      settle_cnt <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
      if (settle_cnt != SET_W'(SYNC_STAGES))
        settle_cnt <= settle_cnt + SET_W'(1);
    end
  end

  assign settled   = (settle_cnt == SET_W'(SYNC_STAGES));
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  assign active   = (state == ACTIVE);
  assign busy     = active;
  assign miso_oe  = active;
  assign miso     = active & tx_shift[DATA_W-1];
  assign rx_next  = {rx_shift, mosi_s};
  assign word_end = active & sclk_rise & (bit_cnt == CNT_W'(DATA_W - 1));
  // A trailing sclk fall that arrives together with cs rise ends the frame
  // instead of opening another word.
  assign word_start = ((state == IDLE) & cs_fall) |
                      (active & sclk_fall & word_done & ~cs_rise);

  // Frame state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_IDLE;
    else     state <= state_next;
  end

  // Frame sequencing: a cs already low at reset release is never taken as a frame
  always_comb begin
    state_next = state;
    case (state)
      WAIT_IDLE: if (settled && cs_s) state_next = IDLE;
      IDLE:      if (cs_fall)         state_next = ACTIVE;
      ACTIVE:    if (cs_rise)         state_next = IDLE;
      default:                        state_next = WAIT_IDLE;
    endcase
  end

  // Transmit side: holding register, word start hand-off and miso shifting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holding     <= '0;
      tx_pend     <= 1'b0;
      tx_shift    <= '0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      if (tx_load) begin
        holding <= tx_data;
        tx_pend <= 1'b1;
      end
      if (word_start) begin
        tx_shift    <= tx_load ? tx_data : holding;
        tx_pend     <= 1'b0;
        tx_underrun <= ~tx_pend & ~tx_load;
      end else if (active && sclk_fall && !cs_rise) begin
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Receive side: mosi deserialiser, bit counter, word completion and framing errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      bit_cnt   <= '0;
      word_done <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (active && sclk_rise) begin
        rx_shift <= rx_next[DATA_W-2:0];
        if (word_end) begin
          rx_data   <= rx_next;
          rx_valid  <= 1'b1;
          bit_cnt   <= '0;
          word_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
      if (word_start)
        word_done <= 1'b0;
      if (active && cs_rise) begin
        frame_err <= (bit_cnt != '0) && !word_end;
        bit_cnt   <= '0;
        word_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_s.sv
// tb_spi_s: randomized self-checking bench for spi_s acting as an SPI master.
// sclk runs at clk/10; the reference model tracks the transmit holding value
// per word and the expected receive words per frame.
module tb_spi_s;

  localparam int DATA_W      = 32;
  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              sclk, cs, mosi;
  logic              miso, miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_underrun;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, frame_err, busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] rx_q[$];
  int                fe_cnt = 0;
  int                ur_cnt = 0;

  logic [DATA_W-1:0] m_hold;
  bit                m_pend;
  logic [DATA_W-1:0] exp_rx_data;

  logic [DATA_W-1:0] fr_mosi[4];
  logic [DATA_W-1:0] ld_val[4];
  bit                ld_en[4];
  int                ld_bit[4];

  spi_s #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .tx_underrun(tx_underrun), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Collect output pulses away from the active edge
  always @(negedge clk) begin
    if (rx_valid)    rx_q.push_back(rx_data);
    if (frame_err)   fe_cnt++;
    if (tx_underrun) ur_cnt++;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic loadTx(input logic [DATA_W-1:0] v);
    @(negedge clk);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    m_hold  = v;
    m_pend  = 1'b1;
  endtask

  task automatic clearFrame();
    for (int i = 0; i < 4; i++) begin
      ld_en[i]  = 1'b0;
      ld_bit[i] = 0;
      ld_val[i] = '0;
    end
  endtask

  // One cs-low frame of nwords words. cut>0 stops after that many bits;
  // keep_cs leaves cs low at the stop. A load at bit 0 lands in the same clk
  // as the detected word start (SYNC_STAGES=2 timing).
  task automatic applyStimulus(input int nwords, input int cut, input bit keep_cs);
    int                fe0, ur0, rx0, ur_exp, fe_exp, bits_done, nb, n_cmp;
    logic [DATA_W-1:0] got, exp_w;
    logic [DATA_W-1:0] exp_q[$];
    bit                stop;
    fe0 = fe_cnt; ur0 = ur_cnt; rx0 = rx_q.size();
    ur_exp = 0; fe_exp = 0; bits_done = 0; stop = 1'b0; got = '0;
    @(negedge clk);
    cs = 1'b0;
    for (int w = 0; w < nwords && !stop; w++) begin
      if (ld_en[w] && ld_bit[w] == 0) begin
        exp_w  = ld_val[w];
        m_hold = ld_val[w];
        m_pend = 1'b0;
      end else begin
        exp_w = m_hold;
        if (!m_pend) ur_exp++;
        m_pend = 1'b0;
      end
      nb = 0;
      for (int b = 0; b < DATA_W && !stop; b++) begin
        mosi = fr_mosi[w][DATA_W-1-b];
        if (ld_en[w] && ld_bit[w] == b) begin
          waitClk(2);
          tx_data = ld_val[w];
          tx_load = 1'b1;
          waitClk(1);
          tx_load = 1'b0;
          if (b != 0) begin
            m_hold = ld_val[w];
            m_pend = 1'b1;
          end
          waitClk(2);
        end else begin
          waitClk(5);
        end
        sclk = 1'b1;
        got[DATA_W-1-b] = miso;
        if (w == 0 && b == 0) checkOutput("active_flags", 64'({busy, miso_oe}), 64'd3);
        waitClk(5);
        nb++;
        bits_done++;
        stop = (cut != 0 && bits_done == cut) || (w == nwords - 1 && b == DATA_W - 1);
        if (stop && !keep_cs) cs = 1'b1;
        sclk = 1'b0;
      end
      if (nb == DATA_W) begin
        checkOutput($sformatf("miso_word%0d", w), 64'(got), 64'(exp_w));
        exp_q.push_back(fr_mosi[w]);
        exp_rx_data = fr_mosi[w];
      end else if (!keep_cs) begin
        fe_exp = 1;
      end
    end
    waitClk(10);
    checkOutput("rx_count", 64'(rx_q.size() - rx0), 64'(exp_q.size()));
    n_cmp = (rx_q.size() - rx0 < exp_q.size()) ? rx_q.size() - rx0 : exp_q.size();
    for (int i = 0; i < n_cmp; i++)
      checkOutput($sformatf("rx_word%0d", i), 64'(rx_q[rx0+i]), 64'(exp_q[i]));
    checkOutput("frame_err_pulses", 64'(fe_cnt - fe0), 64'(fe_exp));
    checkOutput("underrun_pulses", 64'(ur_cnt - ur0), 64'(ur_exp));
    checkOutput("rx_data_held", 64'(rx_data), 64'(exp_rx_data));
    if (!keep_cs) checkOutput("idle_after_frame", 64'({busy, miso_oe, miso}), 64'd0);
  endtask

  initial begin
    int rx0;
    int busy_seen;
    int nw;
    int cut;
    rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_load = 1'b0;
    m_hold = '0; m_pend = 1'b0; exp_rx_data = '0;
    clearFrame();
    waitClk(3);
    checkOutput("reset_flags", 64'({miso, miso_oe, rx_valid, tx_underrun, frame_err, busy}), 64'd0);
    checkOutput("reset_rx_data", 64'(rx_data), 64'd0);
    rst = 1'b0;
    waitClk(10);

    $display("[TB] single word");
    fr_mosi[0] = 32'hAAAA_AAA8;
    loadTx(32'hA5A5_0001);
    applyStimulus(1, 0, 1'b0);

    $display("[TB] two words, reload mid word 1");
    loadTx($urandom);
    fr_mosi[0] = $urandom; fr_mosi[1] = $urandom;
    ld_en[0] = 1'b1; ld_bit[0] = 12; ld_val[0] = 32'h1234_5678;
    applyStimulus(2, 0, 1'b0);

    $display("[TB] truncated frame then full frame");
    clearFrame();
    loadTx($urandom);
    fr_mosi[0] = $urandom;
    applyStimulus(1, 10, 1'b0);
    loadTx($urandom);
    fr_mosi[0] = $urandom;
    applyStimulus(1, 0, 1'b0);

    $display("[TB] frame without reload");
    fr_mosi[0] = $urandom;
    applyStimulus(1, 0, 1'b0);

    $display("[TB] reset mid frame");
    loadTx($urandom);
    fr_mosi[0] = $urandom;
    applyStimulus(1, 16, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    waitClk(1);
    checkOutput("midrst_flags", 64'({miso, miso_oe, rx_valid, tx_underrun, frame_err, busy}), 64'd0);
    checkOutput("midrst_rx_data", 64'(rx_data), 64'd0);
    waitClk(1);
    rst = 1'b0;
    m_hold = '0; m_pend = 1'b0; exp_rx_data = '0;
    rx0 = rx_q.size();
    busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      mosi = 1'($urandom_range(0, 1));
      waitClk(5);
      sclk = 1'b1;
      if (busy) busy_seen++;
      waitClk(5);
      sclk = 1'b0;
      if (busy) busy_seen++;
    end
    checkOutput("cs_low_after_rst_busy", 64'(busy_seen), 64'd0);
    checkOutput("cs_low_after_rst_rx", 64'(rx_q.size() - rx0), 64'd0);
    cs = 1'b1;
    waitClk(10);
    loadTx($urandom);
    fr_mosi[0] = $urandom;
    applyStimulus(1, 0, 1'b0);

    $display("[TB] load in same clk as cs fall");
    clearFrame();
    fr_mosi[0] = $urandom;
    ld_en[0] = 1'b1; ld_bit[0] = 0; ld_val[0] = 32'hDEAD_BEEF;
    applyStimulus(1, 0, 1'b0);

    $display("[TB] random frames");
    for (int f = 0; f < 10; f++) begin
      nw  = $urandom_range(1, 3);
      cut = 0;
      clearFrame();
      for (int w = 0; w < nw; w++) begin
        fr_mosi[w] = $urandom;
        ld_en[w]   = ($urandom_range(0, 2) != 0);
        ld_bit[w]  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(2, 29);
        ld_val[w]  = $urandom;
      end
      if ($urandom_range(0, 3) == 0) cut = $urandom_range(1, nw * DATA_W - 1);
      if ($urandom_range(0, 1) == 1) loadTx($urandom);
      applyStimulus(nw, cut, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
